// File: rtl/imem_responder_if.sv
// Instruction-fetch read port plus program-image load port of the imem responder.
// The master side is the core/loader, the slave side is the responder.
interface imem_responder_if;
  logic [31:0] read_req;
  logic [31:0] read_value;
  logic        load_valid;
  logic        load_ready;
  logic [31:0] load_addr;
  logic [31:0] load_data;
  logic        load_last;

  modport master (
    output read_req,
    output load_valid,
    output load_addr,
    output load_data,
    output load_last,
    input  read_value,
    input  load_ready
  );

  modport slave (
    input  read_req,
    input  load_valid,
    input  load_addr,
    input  load_data,
    input  load_last,
    output read_value,
    output load_ready
  );
endinterface

// File: rtl/imem_responder.sv
// Responder end of the core's instruction-fetch port.
// After reset it sits in LOAD and accepts a program image over the valid/ready
// load port; the beat flagged last moves it to RUN, where every edge returns the
// word addressed by the core's next PC one cycle later. Bad addresses return the
// NOP word and set sticky error flags. The program memory itself is never reset,
// so a later reset followed by a partial reload keeps the untouched words.
module imem_responder #(
  parameter int          DEPTH_WORDS = 1024,
  parameter logic [31:0] NOP_WORD    = 32'h0000_0013,
  localparam int         IDX_W       = $clog2(DEPTH_WORDS)
) (
  input  logic                clk,
  input  logic                rst,
  imem_responder_if.slave     bus,
  output logic                running,
  output logic [15:0]         load_count,
  output logic                err_misaligned,
  output logic                err_oob
);

  typedef enum logic {
    ST_LOAD,
    ST_RUN
  } state_t;

  // First byte address past the end of memory, one bit wider than the bus so
  // that the compare stays exact even for the largest legal depth.
  localparam logic [32:0] BYTE_LIMIT = 33'(DEPTH_WORDS) << 2;

  logic [31:0] mem [DEPTH_WORDS];

  state_t      state_q, state_d;
  logic        running_q, running_d;
  logic [15:0] load_count_q, load_count_d;
  logic        err_misaligned_q, err_misaligned_d;
  logic        err_oob_q, err_oob_d;
  logic        nop_sel_q, nop_sel_d;
  logic [31:0] mem_rdata_q;

  logic             load_misaligned;
  logic             load_oob;
  logic             read_misaligned;
  logic             read_oob;
  logic             mem_we;
  logic             mem_re;
  logic [IDX_W-1:0] load_idx;
  logic [IDX_W-1:0] read_idx;

  // Address qualification for both ports; the full 32-bit address is compared so
  // that high bits can never alias back into the word index.
  always_comb begin
    load_misaligned = (bus.load_addr[1:0] != 2'b00);
    load_oob        = ({1'b0, bus.load_addr} >= BYTE_LIMIT);
    read_misaligned = (bus.read_req[1:0] != 2'b00);
    read_oob        = ({1'b0, bus.read_req} >= BYTE_LIMIT);
    load_idx        = bus.load_addr[IDX_W+1:2];
    read_idx        = bus.read_req[IDX_W+1:2];
    mem_we          = (state_q == ST_LOAD) && bus.load_valid && !load_misaligned && !load_oob;
    mem_re          = (state_q == ST_RUN);
  end

  // Next-state logic: LOAD counts and screens beats until the last one, RUN
  // screens fetch addresses and decides whether the fetched word or NOP goes out.
  always_comb begin
    state_d          = state_q;
    load_count_d     = load_count_q;
    err_misaligned_d = err_misaligned_q;
    err_oob_d        = err_oob_q;
    nop_sel_d        = 1'b1;

    case (state_q)
      ST_LOAD: begin
        if (bus.load_valid) begin
          if (load_count_q != 16'hFFFF) begin
            load_count_d = load_count_q + 16'd1;
          end
          if (load_misaligned) begin
            err_misaligned_d = 1'b1;
          end
          if (load_oob) begin
            err_oob_d = 1'b1;
          end
          if (bus.load_last) begin
            state_d = ST_RUN;
          end
        end
      end
      ST_RUN: begin
        if (read_misaligned) begin
          err_misaligned_d = 1'b1;
        end
        if (read_oob) begin
          err_oob_d = 1'b1;
        end
        nop_sel_d = read_misaligned || read_oob;
      end
    endcase

    running_d = (state_d == ST_RUN);
  end

  // Control and status registers; an asserted reset returns to LOAD at once and
  // forces the fetch output to NOP without waiting for a clock edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q          <= ST_LOAD;
      running_q        <= 1'b0;
      load_count_q     <= 16'd0;
      err_misaligned_q <= 1'b0;
      err_oob_q        <= 1'b0;
      nop_sel_q        <= 1'b1;
    end else begin
      state_q          <= state_d;
      running_q        <= running_d;
      load_count_q     <= load_count_d;
      err_misaligned_q <= err_misaligned_d;
      err_oob_q        <= err_oob_d;
      nop_sel_q        <= nop_sel_d;
    end
  end

  // Program memory write port, used only while loading; not reset so the image
  // survives a reset and can be partially overwritten.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[load_idx] <= bus.load_data;
    end
  end

  // Synchronous memory read port kept free of reset so it maps onto block RAM;
  // the resettable NOP select in front of it supplies the reset value.
  always_ff @(posedge clk) begin
    if (mem_re) begin
      mem_rdata_q <= mem[read_idx];
    end
  end

  assign bus.read_value = nop_sel_q ? NOP_WORD : mem_rdata_q;
  assign bus.load_ready = (state_q == ST_LOAD);
  assign running        = running_q;
  assign load_count     = load_count_q;
  assign err_misaligned = err_misaligned_q;
  assign err_oob        = err_oob_q;

endmodule
